bcd_digit_pair_counter: RTL and testbench
=========================================

// Module: bcd_digit_pair_counter
// PURPOSE
//   Parametrised two-digit BCD counter for one clock field (seconds, minutes,
//   hours). It counts on an enable tick, wraps at a programmable modulus, and
//   emits a carry pulse so that fields chain (sec -> min -> hour).
//   It adds synchronous load, a SET mode with manual increment, and digit-point
//   indication. It drives the digit/point LED outputs directly.
// PARAMETERS
//   MODULUS  60  count range upper bound (exclusive); legal 2..100
//   MIN_VAL  0   wrap/reset value; 1 gives a 12h field (MODULUS=13); MIN_VAL < MODULUS-1
//   LEFT_W   3   left digit width; requires (MODULUS-1)/10 < 2**LEFT_W
// PORTS
//   clk         in   1       system clock, all state on rising edge
//   rst_n       in   1       asynchronous reset, active low
//   tick        in   1       count enable, 1-cycle pulse (e.g. 1 Hz strobe or upstream carry_out)
//   set_req     in   1       1-cycle pulse, toggles RUN <-> SET
//   inc         in   1       1-cycle pulse, manual +1 (SET state only)
//   load        in   1       synchronous load strobe
//   load_left   in   LEFT_W  left digit to load
//   load_right  in   4       right digit to load
//   left_digit  out  LEFT_W  tens digit (BCD), registered
//   right_digit out  4       units digit (BCD), registered
//   lps         out  1       left digit point
//   rps         out  1       right digit point
//   carry_out   out  1       1-cycle pulse on RUN wrap MODULUS-1 -> MIN_VAL
//   load_err    out  1       1-cycle pulse, load rejected
//   in_set      out  1       1 while in SET state
// BEHAVIOUR
//   - Reset (rst_n low, async): digits = MIN_VAL/10, MIN_VAL%10; state RUN;
//     carry_out, load_err, lps, rps, in_set = 0. All outputs registered.
//   - Value V = 10*left + right. Increment: right 9 -> 0 with left+1.
//     If V == MODULUS-1, next V = MIN_VAL. right_digit never exceeds 9.
//   - Latency: a sampled strobe is visible on the outputs 1 clk later;
//     carry_out asserts in the same cycle the wrapped value appears.
//   - FSM RUN: tick increments V. A wrap pulses carry_out. inc is ignored.
//   - FSM SET: tick does not change V (field frozen). inc increments with
//     wrap and never pulses carry_out. in_set = 1.
//   - set_req toggles the state. When set_req and inc coincide, set_req acts
//     and inc is dropped. When set_req and tick coincide in RUN, the tick
//     counts, then the state becomes SET.
//   - load: highest priority, legal in both states, state unchanged.
//     Accepted only if load_right <= 9 and MIN_VAL <= V_load < MODULUS.
//     Otherwise V is unchanged and load_err pulses. A coincident tick or inc
//     is dropped. A load never produces carry_out.
//   - lps/rps: 0 in RUN. On entering SET, both = 1. On leaving SET, both = 0
//     next cycle.
//   - Reset mid-operation: immediate return to reset values. A pending
//     carry_out or load_err pulse is cleared.
// CONFIGURATION
//   DIGIT_PAIR_BLINK_EN defined: in SET, lps and rps toggle together on every
//     tick, using tick as the blink timebase.
//   Not defined: in SET, lps = rps = 1 steady. No toggle register is built.
// TESTING
//   1. V=59 (defaults), tick -> next cycle 00, carry_out=1 for exactly 1 clk.
//   2. MODULUS=13, MIN_VAL=1, V=12, tick -> 01 with carry_out. Reset -> 01.
//   3. load 6,0 -> V unchanged, load_err 1 clk. Load 4,5 -> 45, no load_err.
//   4. V=58, set_req, 3 ticks -> stays 58. inc x3 -> 59,00,01 with carry_out=0.
//      set_req -> RUN, lps=rps=0.
//   5. BLINK_EN defined, in SET, 4 ticks -> lps/rps 1,0,1,0,1 (incl. entry);
//      not defined -> steady 1.
//   6. V=59, load 1,2 with coincident tick -> 12, no carry. rst_n low
//      mid-count at 37 -> 00 asynchronously.

Source files
------------

// File: rtl/bcd_digit_pair_counter.sv
// Two-digit BCD counter for one clock field with programmable modulus, RUN/SET modes, load and digit points.
// Optional build macro DIGIT_PAIR_BLINK_EN: digit points blink on tick while in SET (steady otherwise).
module bcd_digit_pair_counter #(
  parameter int MODULUS = 60,
  parameter int MIN_VAL = 0,
  parameter int LEFT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              set_req,
  input  logic              inc,
  input  logic              load,
  input  logic [LEFT_W-1:0] load_left,
  input  logic [3:0]        load_right,
  output logic [LEFT_W-1:0] left_digit,
  output logic [3:0]        right_digit,
  output logic              lps,
  output logic              rps,
  output logic              carry_out,
  output logic              load_err,
  output logic              in_set
);

  localparam logic [LEFT_W-1:0] MAX_L = LEFT_W'((MODULUS - 1) / 10);
  localparam logic [3:0]        MAX_R = 4'((MODULUS - 1) % 10);
  localparam logic [LEFT_W-1:0] MIN_L = LEFT_W'(MIN_VAL / 10);
  localparam logic [3:0]        MIN_R = 4'(MIN_VAL % 10);

  typedef enum logic {S_RUN, S_SET} state_t;

  state_t              state, state_n;
  logic [LEFT_W-1:0]   left_n;
  logic [3:0]          right_n;
  logic                carry_n, err_n;
  logic [31:0]         v_load;
  logic                load_ok;
  logic                at_max;
  logic [LEFT_W+3:0]   inc_val;

  // BCD +1 with wrap from MODULUS-1 back to MIN_VAL; {left, right}
  function automatic logic [LEFT_W+3:0] bcd_inc(input logic [LEFT_W-1:0] l,
                                                input logic [3:0]        r);
    if (l == MAX_L && r == MAX_R)
      return {MIN_L, MIN_R};
    else if (r == 4'd9)
      return {l + LEFT_W'(1), 4'd0};
    else
      return {l, r + 4'd1};
  endfunction

  assign v_load  = 32'(load_left) * 32'd10 + 32'(load_right);
  assign load_ok = (load_right <= 4'd9) && (v_load >= $unsigned(MIN_VAL)) &&
                   (v_load < $unsigned(MODULUS));
  assign at_max  = (left_digit == MAX_L) && (right_digit == MAX_R);
  assign inc_val = bcd_inc(left_digit, right_digit);

  always_comb begin
    state_n = state;
    left_n  = left_digit;
    right_n = right_digit;
    carry_n = 1'b0;
    err_n   = 1'b0;
    if (load) begin
      // load overrides everything else, including a mode toggle
      if (load_ok) begin
        left_n  = load_left;
        right_n = load_right;
      end else begin
        err_n = 1'b1;
      end
    end else if (state == S_RUN) begin
      if (tick) begin
        {left_n, right_n} = inc_val;
        carry_n = at_max;
      end
      if (set_req) state_n = S_SET;
    end else begin
      if (set_req)
        state_n = S_RUN;
      else if (inc)
        {left_n, right_n} = inc_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RUN;
      left_digit  <= MIN_L;
      right_digit <= MIN_R;
      carry_out   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      state       <= state_n;
      left_digit  <= left_n;
      right_digit <= right_n;
      carry_out   <= carry_n;
      load_err    <= err_n;
    end
  end

  assign in_set = (state == S_SET);

`ifdef DIGIT_PAIR_BLINK_EN
  logic pt, pt_n;

  // points light on SET entry, toggle on each tick while in SET, clear on exit
  always_comb begin
    pt_n = pt;
    if (state_n == S_RUN)
      pt_n = 1'b0;
    else if (state == S_RUN)
      pt_n = 1'b1;
    else if (tick)
      pt_n = ~pt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pt <= 1'b0;
    else        pt <= pt_n;
  end

  assign lps = pt;
  assign rps = pt;
`else
  assign lps = in_set;
  assign rps = in_set;
`endif

endmodule

// File: tb/tb_bcd_digit_pair_counter.sv
// Randomized bench for bcd_digit_pair_counter: a 60/0 field and a 13/1 (12h) field share stimulus,
// each checked every cycle against an integer-valued behavioural model, plus directed literal checks.
module tb_bcd_digit_pair_counter;

`ifdef DIGIT_PAIR_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, set_req = 1'b0, inc = 1'b0, load = 1'b0;
  logic [2:0] load_left = 3'd0;
  logic [3:0] load_right = 4'd0;

  logic [2:0] a_left, b_left;
  logic [3:0] a_right, b_right;
  logic       a_lps, a_rps, a_carry, a_err, a_set;
  logic       b_lps, b_rps, b_carry, b_err, b_set;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bcd_digit_pair_counter dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_req(set_req), .inc(inc), .load(load),
    .load_left(load_left), .load_right(load_right),
    .left_digit(a_left), .right_digit(a_right), .lps(a_lps), .rps(a_rps),
    .carry_out(a_carry), .load_err(a_err), .in_set(a_set)
  );

  bcd_digit_pair_counter #(.MODULUS(13), .MIN_VAL(1), .LEFT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_req(set_req), .inc(inc), .load(load),
    .load_left(load_left), .load_right(load_right),
    .left_digit(b_left), .right_digit(b_right), .lps(b_lps), .rps(b_rps),
    .carry_out(b_carry), .load_err(b_err), .in_set(b_set)
  );

  typedef struct packed {
    int v;
    bit set_st;
    bit pt;
    bit carry;
    bit lerr;
  } model_t;

  function automatic model_t mreset(input int mn);
    model_t n;
    n.v = mn; n.set_st = 0; n.pt = 0; n.carry = 0; n.lerr = 0;
    return n;
  endfunction

  function automatic model_t mstep(input model_t s, input int m, input int mn,
                                   input bit tk, input bit sr, input bit ic, input bit ld,
                                   input int ll, input int lr);
    model_t n = s;
    int vl;
    n.carry = 0;
    n.lerr = 0;
    vl = 10 * ll + lr;
    if (ld) begin
      if (lr <= 9 && vl >= mn && vl < m) n.v = vl;
      else n.lerr = 1;
      if (s.set_st && tk && BLINK) n.pt = !s.pt;
    end else if (!s.set_st) begin
      if (tk) begin
        if (s.v == m - 1) begin n.v = mn; n.carry = 1; end
        else n.v = s.v + 1;
      end
      if (sr) begin n.set_st = 1; n.pt = 1; end
    end else if (sr) begin
      n.set_st = 0; n.pt = 0;
    end else begin
      if (ic) n.v = (s.v == m - 1) ? mn : s.v + 1;
      if (tk && BLINK) n.pt = !s.pt;
    end
    return n;
  endfunction

  model_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= mreset(0);
      mb <= mreset(1);
    end else begin
      ma <= mstep(ma, 60, 0, tick, set_req, inc, load, int'(load_left), int'(load_right));
      mb <= mstep(mb, 13, 1, tick, set_req, inc, load, int'(load_left), int'(load_right));
    end
  end

  task automatic cmp(input string nm, input model_t m, input logic [2:0] l, input logic [3:0] r,
                     input logic c, input logic e, input logic lp, input logic rp, input logic is);
    logic [11:0] got, exp;
    got = {l, r, c, e, lp, rp, is};
    exp = {3'(m.v / 10), 4'(m.v % 10), m.carry, m.lerr, m.pt, m.pt, m.set_st};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got {l,r,c,e,lp,rp,set}=%h required %h", nm, $time, got, exp);
  endtask

  always @(negedge clk) begin
    cmp("model_a", ma, a_left, a_right, a_carry, a_err, a_lps, a_rps, a_set);
    cmp("model_b", mb, b_left, b_right, b_carry, b_err, b_lps, b_rps, b_set);
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, got, exp);
  endtask

  task automatic drv(input bit tk, input bit sr, input bit ic, input bit ld,
                     input int ll, input int lr);
    tick = tk; set_req = sr; inc = ic; load = ld;
    load_left = 3'(ll); load_right = 4'(lr);
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    tick = 0; set_req = 0; inc = 0; load = 0;
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int av, bv;
    repeat (2) @(negedge clk);
    chk("reset_a_val", 10 * a_left + a_right, 0);
    chk("reset_b_val", 10 * b_left + b_right, 1);
    chk("reset_a_outs", {a_carry, a_err, a_lps, a_rps, a_set}, 0);
    rst_n = 1'b1;

    drv(0, 0, 0, 1, 5, 9);
    chk("load59_a", 10 * a_left + a_right, 59);
    chk("load59_b_err", b_err, 1);
    drv(1, 0, 0, 0, 0, 0);
    chk("wrap_a_val", 10 * a_left + a_right, 0);
    chk("wrap_a_carry", a_carry, 1);
    idle();
    chk("carry_one_clk", a_carry, 0);

    drv(0, 0, 0, 1, 1, 2);
    drv(1, 0, 0, 0, 0, 0);
    chk("wrap12h_b_val", 10 * b_left + b_right, 1);
    chk("wrap12h_b_carry", b_carry, 1);

    drv(0, 0, 0, 1, 6, 0);
    chk("bad_load_err", a_err, 1);
    chk("bad_load_val", 10 * a_left + a_right, 13);
    drv(0, 0, 0, 1, 4, 5);
    chk("good_load_val", 10 * a_left + a_right, 45);
    chk("good_load_noerr", a_err, 0);

    drv(0, 0, 0, 1, 5, 8);
    drv(0, 1, 0, 0, 0, 0);
    chk("set_entry_in_set", a_set, 1);
    chk("set_entry_lps", a_lps, 1);
    for (int i = 1; i <= 4; i++) begin
      drv(1, 0, 0, 0, 0, 0);
      chk("set_tick_frozen", 10 * a_left + a_right, 58);
      chk("set_blink_lps", a_lps, BLINK ? ((i % 2 == 0) ? 1 : 0) : 1);
      chk("set_blink_rps", a_rps, BLINK ? ((i % 2 == 0) ? 1 : 0) : 1);
    end
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 0, 0, 0);
      av = (i == 0) ? 59 : (i == 1) ? 0 : 1;
      chk("set_inc_val", 10 * a_left + a_right, av);
      chk("set_inc_nocarry", a_carry, 0);
    end
    drv(0, 1, 0, 0, 0, 0);
    chk("set_exit_in_set", a_set, 0);
    chk("set_exit_points", {a_lps, a_rps}, 0);

    drv(0, 0, 0, 1, 5, 9);
    drv(1, 0, 0, 1, 1, 2);
    chk("load_over_tick_val", 10 * a_left + a_right, 12);
    chk("load_over_tick_carry", a_carry, 0);

    drv(0, 0, 0, 1, 3, 7);
    tick = 0; load = 0;
    #2 rst_n = 1'b0;
    #1;
    av = 10 * a_left + a_right;
    bv = 10 * b_left + b_right;
    chk("async_reset_a", av, 0);
    chk("async_reset_b", bv, 1);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (4000) begin
      if ($urandom_range(0, 599) == 0) async_reset();
      else drv($urandom_range(0, 2) == 0, $urandom_range(0, 14) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
               int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
